// File: rtl/edge_tick_gen.sv
// Multi-channel edge-to-tick converter: synchroniser, optional debounce filter,
// per-channel edge select, one-cycle tick and wrapping tick counter.
// Optional debounce is built when EDGE_TICK_DEBOUNCE_EN is defined.
module edge_tick_gen #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         din,
  input  logic [2*N-1:0]       mode,
  input  logic [N-1:0]         clr,
  output logic [N-1:0]         level,
  output logic [N-1:0]         tick,
  output logic [N*CNT_W-1:0]   cnt,
  output logic                 any_tick
);

  logic [SYNC_STAGES-1:0] sync_q [N];
  logic [N-1:0]           s;
  logic [N-1:0]           level_nxt;
  logic [N-1:0]           tick_nxt;
  logic [CNT_W-1:0]       cnt_q [N];

  // Synchroniser chains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], din[i]};
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) s[i] = sync_q[i][SYNC_STAGES-1];
  end

`ifdef EDGE_TICK_DEBOUNCE_EN
  localparam int              DB_W    = $clog2(DB_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] db_q [N];

  // Level flips only after s has disagreed with it for DB_CYCLES consecutive cycles
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < N; i++) begin
      if ((s[i] != level[i]) && (db_q[i] == DB_LAST)) level_nxt[i] = ~level[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) db_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((s[i] == level[i]) || (db_q[i] == DB_LAST)) db_q[i] <= '0;
        else                                            db_q[i] <= db_q[i] + 1'b1;
      end
    end
  end
`else
  always_comb begin
    level_nxt = s;
  end
`endif

  // Edge qualification against the live mode bits: bit 2i = rise, bit 2i+1 = fall
  always_comb begin
    tick_nxt = '0;
    for (int i = 0; i < N; i++) begin
      tick_nxt[i] = (level_nxt[i] & ~level[i] & mode[2*i]) |
                    (~level_nxt[i] & level[i] & mode[2*i+1]);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level    <= '0;
      tick     <= '0;
      any_tick <= 1'b0;
    end else begin
      level    <= level_nxt;
      tick     <= tick_nxt;
      any_tick <= |tick_nxt;
    end
  end

  // Counters follow the registered tick, so they lag it by one cycle; clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr[i])       cnt_q[i] <= '0;
        else if (tick[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_edge_tick_gen.sv
// Directed bench for edge_tick_gen: behavioural reference model compared every
// cycle, plus hand-computed latency and count expectations.
module tb_edge_tick_gen;
  localparam int N     = 4;
  localparam int SS    = 2;
  localparam int DB    = 16;
  localparam int CNT_W = 8;
  localparam int HL    = SS + DB + 1;
`ifdef EDGE_TICK_DEBOUNCE_EN
  localparam int L     = SS + DB - 1;
  localparam int HOLD  = 20;
`else
  localparam int L     = SS;
  localparam int HOLD  = 2;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       din;
  logic [2*N-1:0]     mode;
  logic [N-1:0]       clr;
  logic [N-1:0]       level;
  logic [N-1:0]       tick;
  logic [N*CNT_W-1:0] cnt;
  logic               any_tick;

  int checks = 0;
  int errors = 0;

  edge_tick_gen #(.N(N), .SYNC_STAGES(SS), .DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .level(level), .tick(tick), .cnt(cnt), .any_tick(any_tick)
  );

  always #5 clk = ~clk;

  // Reference model: m_hist[j] holds the din sample taken j+1 edges ago.
  logic [N-1:0]     m_hist [HL];
  logic [N-1:0]     m_lvl;
  logic [N-1:0]     m_tick;
  logic             m_any;
  logic [CNT_W-1:0] m_cnt [N];

  function automatic logic [N-1:0] next_level();
    logic [N-1:0] nl;
    nl = m_lvl;
`ifdef EDGE_TICK_DEBOUNCE_EN
    for (int i = 0; i < N; i++) begin
      logic all_diff;
      all_diff = 1'b1;
      for (int m = 0; m < DB; m++)
        if (m_hist[SS-1+m][i] == m_lvl[i]) all_diff = 1'b0;
      if (all_diff) nl[i] = ~m_lvl[i];
    end
`else
    nl = m_hist[SS-1];
`endif
    return nl;
  endfunction

  function automatic logic [N-1:0] next_tick(input logic [N-1:0] nl);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      if (nl[i] && !m_lvl[i])      t[i] = mode[2*i];
      else if (!nl[i] && m_lvl[i]) t[i] = mode[2*i+1];
      else                         t[i] = 1'b0;
    end
    return t;
  endfunction

  function automatic logic [N*CNT_W-1:0] m_cnt_flat();
    logic [N*CNT_W-1:0] f;
    for (int i = 0; i < N; i++) f[i*CNT_W +: CNT_W] = m_cnt[i];
    return f;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < HL; j++) m_hist[j] <= '0;
      m_lvl  <= '0;
      m_tick <= '0;
      m_any  <= 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        m_cnt[i] <= clr[i] ? '0 : m_cnt[i] + CNT_W'(m_tick[i]);
      m_tick <= next_tick(next_level());
      m_any  <= |next_tick(next_level());
      m_lvl  <= next_level();
      for (int j = HL - 1; j > 0; j--) m_hist[j] <= m_hist[j-1];
      m_hist[0] <= din;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick[ch] && n < 200);
  endtask

  int n;

  initial begin
    rst  = 1'b0;
    din  = '0;
    mode = 8'h55;
    clr  = '0;
    #3;
    check("rst_level", level, 0);
    check("rst_tick", tick, 0);
    check("rst_cnt", cnt, 0);
    check("rst_any", any_tick, 0);

    fork
      forever begin
        @(negedge clk);
        check("cyc_level", level, m_lvl);
        check("cyc_tick", tick, m_tick);
        check("cyc_any", any_tick, m_any);
        check("cyc_cnt", cnt, m_cnt_flat());
      end
    join_none

    cyc(3);
    rst = 1'b1;
    cyc(5);

    // Single rising edge on channel 0
    din[0] = 1'b1;
    wait_tick(0, n);
    check("lat_rise0", n, L + 1);
    check("tick_only0", tick, 4'b0001);
    cyc(1);
    check("tick_pulse0", tick[0], 0);
    check("cnt0_one", cnt[7:0], 1);

    // Both edges, then falls only, on channel 1
    mode[3:2] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      din[1] = ~din[1];
      cyc(50);
    end
    check("cnt1_both", cnt[15:8], 4);
    clr[1] = 1'b1;
    cyc(1);
    clr[1] = 1'b0;
    mode[3:2] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      din[1] = ~din[1];
      cyc(50);
    end
    check("cnt1_fall", cnt[15:8], 2);

    // Glitch handling on channel 2
    mode[5:4] = 2'b11;
`ifdef EDGE_TICK_DEBOUNCE_EN
    din[2] = 1'b1;
    cyc(10);
    din[2] = 1'b0;
    cyc(40);
    check("glitch_cnt2", cnt[23:16], 0);
    check("glitch_lvl2", level[2], 0);
    din[2] = 1'b1;
    wait_tick(2, n);
    check("lat_db2", n, L + 1);
    cyc(40 - n);
    din[2] = 1'b0;
    cyc(40);
    check("db_cnt2", cnt[23:16], 2);
`else
    din[2] = 1'b1;
    cyc(1);
    din[2] = 1'b0;
    cyc(10);
    check("glitch_cnt2", cnt[23:16], 2);
    check("glitch_lvl2", level[2], 0);
`endif

    // 256 rising edges wrap channel 3, then clear against a tick
    for (int k = 0; k < 256; k++) begin
      din[3] = 1'b1;
      cyc(HOLD);
      din[3] = 1'b0;
      cyc(HOLD);
    end
    cyc(L + 3);
    check("wrap_cnt3", cnt[31:24], 0);
    din[3] = 1'b1;
    wait_tick(3, n);
    cyc(1);
    check("cnt3_one", cnt[31:24], 1);
    din[3] = 1'b0;
    cyc(HOLD + L + 2);
    din[3] = 1'b1;
    wait_tick(3, n);
    clr[3] = 1'b1;
    cyc(1);
    clr[3] = 1'b0;
    check("clr_wins", cnt[31:24], 0);
    din[3] = 1'b0;
    cyc(HOLD + L + 2);

    // Inputs high across reset release tick together
    rst  = 1'b0;
    din  = 4'hF;
    mode = 8'h55;
    cyc(2);
    check("rst_hold_cnt", cnt, 0);
    rst = 1'b1;
    wait_tick(0, n);
    check("lat_rst_rel", n, L + 1);
    check("all_tick", tick, 4'hF);
    check("any_tick_on", any_tick, 1);
    cyc(1);
    check("any_tick_off", any_tick, 0);
    check("all_tick_off", tick, 0);

    // Reset in the middle of a pending edge
    din = '0;
    cyc(L + 5);
    din[0] = 1'b1;
    cyc(3);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_tick", tick, 0);
    check("mid_rst_any", any_tick, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_tick(0, n);
    check("lat_after_rst", n, L + 1);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_tick_gen.md
# edge_tick_gen

Multi-channel, parametrised edge-to-tick converter: synchronises N asynchronous level inputs (slow clock-divider outputs, buttons, mode lines), optionally debounces them, and emits a one-`clk`-cycle tick per qualifying edge, with per-channel edge selection and a per-channel wrapping event counter. It feeds the second/minute counters and control FSMs of the timer designs. It replaces single-channel, rising-edge-only tick generation.

## Interface
- `N`, 4: number of channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel (legal ≥ 2).
- `DB_CYCLES`, 16: cycles a synchronised level must differ from `level` before it is accepted (legal ≥ 1). Used only with debounce compiled in.
- `CNT_W`, 8: width of each per-channel tick counter.
- `clk` input 1: system clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `din` input N: raw asynchronous level inputs.
- `mode` input 2N: per channel `mode[2i+1:2i]`. 00 = off, 01 = rising, 10 = falling, 11 = both edges.
- `clr` input N: synchronous clear of `cnt` for channel i.
- `level` output N: filtered, registered level per channel.
- `tick` output N: registered one-cycle pulse per qualifying edge.
- `cnt` output N*CNT_W: per-channel tick count, `cnt[i*CNT_W +: CNT_W]`.
- `any_tick` output 1: registered OR of `tick`.

## Operation
- Per channel: a synchroniser chain of `SYNC_STAGES` flops produces `s_i`. The filter stage then drives `level[i]`. The edge detector compares the next and current `level[i]`.
- Filter with debounce compiled in:
  - A counter `db_i` of width clog2(DB_CYCLES)+1 increments each cycle while `s_i != level[i]`.
  - `db_i` clears to 0 on any cycle where `s_i == level[i]`.
  - When `s_i != level[i]` and `db_i == DB_CYCLES-1`, `level[i]` toggles on that edge and `db_i` clears.
  - A pulse on `s_i` shorter than `DB_CYCLES` cycles never changes `level`.
- Filter without debounce: `level[i] <= s_i` every cycle.
- Edge qualification, using the same-cycle `level[i]` transition:
  - Rise: 0→1.
  - Fall: 1→0.
  - `tick[i]` is 1 for exactly the cycle in which the new `level[i]` first appears, if the transition matches `mode`. Otherwise `tick[i]` is 0.
- `mode` is sampled combinationally at the transition cycle. A change of `mode` never produces a retroactive tick.
- Counter behaviour:
  - `cnt_i` increments by 1 on each cycle where `tick[i]` is 1.
  - It wraps from 2^CNT_W−1 to 0.
  - `clr[i]` forces `cnt_i` to 0. If `clr[i]` coincides with an incrementing tick, `clr` wins and the result is 0.
- Channels are fully independent. Simultaneous edges on several channels all tick in the same cycle, and `any_tick` is 1.
- Reset (asynchronous, `rst` low) clears synchroniser flops, `db_i`, `level`, `tick`, `cnt` and `any_tick` to 0.
  - Reset mid-debounce discards the partial count.
  - An input that is high when reset releases is treated as a rising edge once it passes the synchroniser and filter. It ticks if `mode` selects rise.

## Timing
- All outputs are registered. There is no combinational path from `din`, `mode` or `clr` to any output.
- Latency, debounce out: a `din` change captured at edge k appears on `level` and `tick` after edge k+SYNC_STAGES.
- Latency, debounce in: a stable `din` change captured at edge k appears on `level` and `tick` after edge k+SYNC_STAGES+DB_CYCLES−1.
- The counter updates on the edge following the `tick` cycle, so `cnt` lags `tick` by 1 cycle.
- `any_tick` is asserted in the same cycle as `tick`.
- `tick` never exceeds 1 cycle per edge. With debounce out, the minimum tick spacing per channel is 1 cycle. With debounce in, it is `DB_CYCLES` cycles.

## Configuration
- `EDGE_TICK_DEBOUNCE_EN`
  - Defined: per-channel `db_i` counters and the filter above are built, and `DB_CYCLES` applies.
  - Undefined: no debounce logic is built, `level` follows the synchroniser output directly, and `DB_CYCLES` is ignored.

## Test plan
- `N`=4, `mode`=01 on all channels, debounce out: `din[0]` 0→1 and held → `tick[0]`=1 for exactly 1 cycle, SYNC_STAGES cycles later. `cnt0`=1 on the next cycle. No ticks on other channels.
- `mode`=11 on channel 1: toggle `din[1]` four times, each level held 50 cycles → 4 ticks on `tick[1]` and `cnt1`=4. With `mode`=10 instead → 2 ticks, falls only.
- Debounce in, `DB_CYCLES`=16:
  - A 10-cycle high glitch on `din[2]` → no `level` change and no tick.
  - A 40-cycle high on `din[2]` → tick 2+15 cycles after capture, then a fall tick after release if `mode` is 11.
- `CNT_W`=8: 256 rising ticks on channel 3 → `cnt3` wraps to 0. `clr[3]` in the same cycle as a tick → `cnt3`=0.
- `din`=all ones while `rst` is low, then release → all channels with `mode`=01 tick once simultaneously, and `any_tick`=1 for 1 cycle.
- Assert `rst` low mid-debounce and mid-count → all outputs 0 immediately. After release, the previously partial edge needs the full latency again.
